// File: rtl/aes_key_schedule_engine.sv
// aes_key_schedule_engine: iterative AES key expansion (128/192/256-bit keys).
// Produces one expanded-key word per clock and caches the last full schedule so
// that back-to-back blocks of the same GCM instance skip re-expansion.
module aes_key_schedule_engine #(
  parameter int KEY_BITS  = 128,
  parameter int PAYLOAD_W = 513
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_valid,
  output logic                              o_ready,
  input  logic [0:KEY_BITS-1]               i_cipher_key,
  input  logic                              i_new_instance,
  input  logic [0:PAYLOAD_W-1]              i_payload,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [0:128*(KEY_BITS/32+7)-1]    o_key_schedule,
  output logic [0:PAYLOAD_W-1]              o_payload
);

  localparam int NK    = KEY_BITS / 32;
  localparam int NR    = NK + 6;
  localparam int NW    = 4 * (NR + 1);
  localparam int IDX_W = $clog2(NW);
  localparam int PH_W  = $clog2(NK);

  // Only the three AES key sizes make sense; anything else stops elaboration.
  if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key_bits
    $error("aes_key_schedule_engine: KEY_BITS must be 128, 192 or 256");
  end

  // AES forward S-box, byte 0x00 in the leftmost position.
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t              state;
  state_t              next_state;
  logic [31:0]         w [NW];
  logic                sched_valid;
  logic [IDX_W-1:0]    idx;
  logic [PH_W-1:0]     phase;
  logic [7:0]          rcon;
  logic [0:PAYLOAD_W-1] payload_q;

  logic                accept;
  logic                miss;
  logic                last_word;
  logic [IDX_W-1:0]    prev_idx;
  logic [IDX_W-1:0]    base_idx;
  logic [31:0]         prev_word;
  logic [31:0]         base_word;
  logic [31:0]         sub_in;
  logic [31:0]         sub_out;
  logic [31:0]         t_word;
  logic [7:0]          rcon_next;

  assign accept    = i_valid & o_ready;
  assign miss      = i_new_instance | ~sched_valid;
  assign last_word = (idx == IDX_W'(NW - 1));
  assign prev_idx  = idx - IDX_W'(1);
  assign base_idx  = idx - IDX_W'(NK);
  assign prev_word = w[prev_idx];
  assign base_word = w[base_idx];

  // The single shared S-box sees the rotated word only on the Rcon step.
  assign sub_in    = (phase == '0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
  assign sub_out   = sub_word(sub_in);
  assign rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

  // Select the mixing term t from the phase within the current key-length group.
  always_comb begin
    t_word = prev_word;
    if (phase == '0) begin
      t_word = sub_out ^ {rcon, 24'h0};
    end else if (NK == 8 && int'(phase) == 4) begin
      t_word = sub_out;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: cache hits skip straight to DONE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = miss ? EXPAND : DONE;
      EXPAND:  if (last_word) next_state = DONE;
      DONE:    if (i_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state alone.
  always_comb begin
    o_ready = (state == IDLE);
    o_valid = (state == DONE);
  end

  // Datapath: key load on a miss, one new word per EXPAND cycle, cache flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NW; k++) w[k] <= '0;
      sched_valid <= 1'b0;
      idx         <= '0;
      phase       <= '0;
      rcon        <= '0;
      payload_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            payload_q <= i_payload;
            if (miss) begin
              for (int k = 0; k < NK; k++) w[k] <= i_cipher_key[32*k +: 32];
              sched_valid <= 1'b0;
              idx         <= IDX_W'(NK);
              phase       <= '0;
              rcon        <= 8'h01;
            end
          end
        end
        EXPAND: begin
          w[idx] <= base_word ^ t_word;
          idx    <= idx + IDX_W'(1);
          phase  <= (int'(phase) == NK - 1) ? '0 : phase + PH_W'(1);
          if (phase == '0) rcon <= rcon_next;
          if (last_word) sched_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NW; i++) begin : g_sched_out
    assign o_key_schedule[32*i +: 32] = w[i];
  end

  assign o_payload = payload_q;

endmodule
